// File: rtl/mpi_pkg.sv
// Shared types for the MPI bus master: FSM states, bus width and cycle-type encodings.
package mpi_pkg;
    localparam int MPI_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SYNC,
        ST_DATA,
        ST_END,
        ST_REL
    } mpi_state_t;

    typedef enum logic {
        DATI = 1'b0,
        DATO = 1'b1
    } mpi_op_t;
endpackage

// File: rtl/mpi_bus_master_if.sv
// Host-side request/completion handshake of the MPI bus master.
interface mpi_bus_master_if;
    import mpi_pkg::*;

    logic              req;
    logic              we;
    logic              byte_en;
    logic [MPI_DW-1:0] addr;
    logic [MPI_DW-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [MPI_DW-1:0] rdata;

    // Requesting host.
    modport master (
        output req, we, byte_en, addr, wdata,
        input  busy, done, err, rdata
    );

    // The bus master block serving the host.
    modport slave (
        input  req, we, byte_en, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/mpi_timeout.sv
// Loadable down-counter for reply timeouts; expired when the count reaches zero.
// Latency: load/decrement take effect on the next edge. No backpressure.
// Holds at zero once expired until reloaded.
module mpi_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic pin_clk,
    input  logic pin_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/mpi_bus_master.sv
// BK-0010 MPI bus master: one-cycle host request -> full address/data cycle with reply timeout.
// Latency: done 6 cycles after req with a zero-wait slave, +1 per slave wait state.
// Backpressure: req is ignored while busy; a req in the done cycle is accepted.
module mpi_bus_master
    import mpi_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              pin_clk,
    input  logic              pin_rst,
    mpi_bus_master_if.slave   host,
    output logic              pin_sync_n,
    output logic              pin_din_n,
    output logic              pin_dout_n,
    output logic              pin_wtbt_n,
    inout  wire  [MPI_DW-1:0] pin_ad_n,
    input  logic              pin_rply_n
);
    mpi_state_t        r_state;
    mpi_op_t           r_op;
    logic              r_byte;
    logic [MPI_DW-1:0] r_wdata;
    logic [MPI_DW-1:0] r_rdata;
    logic [MPI_DW-1:0] r_ad_dat;
    logic              r_ad_oe;
    logic              r_sync_n;
    logic              r_din_n;
    logic              r_dout_n;
    logic              r_wtbt_n;
    logic              r_err_flag;
    logic              r_done;
    logic              r_err;

    logic              w_rply;
    logic              w_expired;
    logic              w_tmr_load;
    logic              w_tmr_dec;

    // An X/Z reply line falls into the else branch and reads as deasserted.
    always_comb begin
        w_rply = 1'b0;
        if (pin_rply_n == 1'b0) begin
            w_rply = 1'b1;
        end
    end

    assign w_tmr_load = (r_state == ST_SYNC) || (r_state == ST_END);
    assign w_tmr_dec  = (r_state == ST_DATA) || (r_state == ST_REL);

    mpi_timeout #(.TIMEOUT(TIMEOUT)) u_tmr (
        .pin_clk   (pin_clk),
        .pin_rst   (pin_rst),
        .i_load    (w_tmr_load),
        .i_dec     (w_tmr_dec),
        .o_expired (w_expired)
    );

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            r_state    <= ST_IDLE;
            r_op       <= DATI;
            r_byte     <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ad_dat   <= '0;
            r_ad_oe    <= 1'b0;
            r_sync_n   <= 1'b1;
            r_din_n    <= 1'b1;
            r_dout_n   <= 1'b1;
            r_wtbt_n   <= 1'b1;
            r_err_flag <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (host.req) begin
                        r_op       <= host.we ? DATO : DATI;
                        r_byte     <= host.byte_en & host.we;
                        r_wdata    <= host.wdata;
                        r_ad_dat   <= ~host.addr;
                        r_ad_oe    <= 1'b1;
                        r_wtbt_n   <= ~host.we;
                        r_err_flag <= 1'b0;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_sync_n <= 1'b0;
                    r_state  <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (r_op == DATO) begin
                        r_ad_dat <= ~r_wdata;
                        r_dout_n <= 1'b0;
                        r_wtbt_n <= ~r_byte;
                    end else begin
                        r_ad_oe  <= 1'b0;
                        r_din_n  <= 1'b0;
                    end
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_rply || w_expired) begin
                        if (w_rply && (r_op == DATI)) begin
                            r_rdata <= ~pin_ad_n;
                        end
                        if (!w_rply) begin
                            r_err_flag <= 1'b1;
                        end
                        r_din_n  <= 1'b1;
                        r_dout_n <= 1'b1;
                        r_wtbt_n <= 1'b1;
                        r_ad_oe  <= 1'b0;
                        r_state  <= ST_END;
                    end
                end
                ST_END: begin
                    r_sync_n <= 1'b1;
                    r_state  <= ST_REL;
                end
                ST_REL: begin
                    // A slave still holding reply at expiry is reported as an error too.
                    if (!w_rply) begin
                        r_done  <= 1'b1;
                        r_err   <= r_err_flag;
                        r_state <= ST_IDLE;
                    end else if (w_expired) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pin_sync_n = r_sync_n;
    assign pin_din_n  = r_din_n;
    assign pin_dout_n = r_dout_n;
    assign pin_wtbt_n = r_wtbt_n;
    assign pin_ad_n   = r_ad_oe ? r_ad_dat : {MPI_DW{1'bz}};

    assign host.busy  = (r_state != ST_IDLE);
    assign host.done  = r_done;
    assign host.err   = r_err;
    assign host.rdata = r_rdata;
endmodule

// File: tb/tb_mpi_bus_master.sv
// Scoreboard bench for mpi_bus_master with a behavioural MPI slave (ROM word + XOR-pattern data).
module tb_mpi_bus_master;
    logic        clk;
    logic        rst;
    logic        pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n;
    wire  [15:0] pin_ad_n;
    wire         pin_rply_n;

    mpi_bus_master_if bus ();

    mpi_bus_master #(.TIMEOUT(16)) dut (
        .pin_clk    (clk),
        .pin_rst    (rst),
        .host       (bus),
        .pin_sync_n (pin_sync_n),
        .pin_din_n  (pin_din_n),
        .pin_dout_n (pin_dout_n),
        .pin_wtbt_n (pin_wtbt_n),
        .pin_ad_n   (pin_ad_n),
        .pin_rply_n (pin_rply_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave
    logic        slv_en;
    int          slv_wait;
    int          slv_wcnt = 0;
    logic [15:0] slv_addr = 16'h0;
    logic [15:0] slv_wr = 16'h0;
    logic        probe_oe;

    function automatic logic [15:0] slv_data(input logic [15:0] a);
        if (a == 16'o100000) return 16'o012345;
        return a ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        if (pin_sync_n) slv_addr <= ~pin_ad_n;
        slv_wcnt <= (!pin_din_n || !pin_dout_n) ? slv_wcnt + 1 : 0;
        if (slv_en && !pin_dout_n && !pin_rply_n) slv_wr <= ~pin_ad_n;
    end

    assign pin_rply_n = ~(slv_en && (!pin_din_n || !pin_dout_n) && (slv_wcnt >= slv_wait));
    assign pin_ad_n   = (slv_en && !pin_din_n) ? ~slv_data(slv_addr) : 16'hzzzz;
    assign pin_ad_n   = probe_oe ? 16'h0000 : 16'hzzzz;

    // Scoreboard
    typedef struct {
        string       name;
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                    chk({e.name, "_err"},   32'(bus.err), 32'(e.err));
                    chk({e.name, "_rdata"}, 32'(bus.rdata), 32'(e.rdata));
                end
                n_done++;
            end
        end
    end

    task automatic start(input string name, input logic we, input logic be,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic e_err, input logic [15:0] e_rdata,
                         input int lat, input logic hold);
        exp_t e;
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.byte_en = be; bus.addr = addr; bus.wdata = wdata;
        e.name = name; e.err = e_err; e.rdata = e_rdata; e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (n_done >= target) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL %s_wait actual=no_done required=done", name);
        end
    endtask

    task automatic chk_float(input string name);
        probe_oe = 1'b1;
        #1;
        chk(name, 32'(pin_ad_n), 32'h0);
        probe_oe = 1'b0;
    endtask

    int dcount;

    initial begin
        rst = 1'b1; probe_oe = 1'b0; slv_en = 1'b1; slv_wait = 0;
        bus.req = 1'b0; bus.we = 1'b0; bus.byte_en = 1'b0; bus.addr = 16'h0; bus.wdata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}), 32'hF);
        chk("rst_busy_done_err", 32'({bus.busy, bus.done, bus.err}), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        chk_float("rst_ad_float");
        rst = 1'b0;

        // ROM read
        start("rom_read", 1'b0, 1'b0, 16'o100000, 16'h0, 1'b0, 16'o012345, 6, 1'b0);
        wait_done("rom_read", 1);

        // Byte write: pins checked per phase
        start("byte_wr", 1'b1, 1'b1, 16'o001001, 16'h5A00, 1'b0, 16'o012345, 6, 1'b0);
        chk("bw_addr_ad", 32'(pin_ad_n), 32'hFDFE);
        chk("bw_addr_strb", 32'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}), 32'hE);
        @(posedge clk); #1;
        chk("bw_sync_ad", 32'({pin_sync_n, pin_ad_n}), 32'h0FDFE);
        @(posedge clk); #1;
        chk("bw_data_strb", 32'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}), 32'h4);
        chk("bw_data_ad", 32'(pin_ad_n), 32'hA5FF);
        wait_done("byte_wr", 2);
        chk("bw_slave_data", 32'(slv_wr), 32'h5A00);

        // Timeout, no slave
        slv_en = 1'b0;
        start("timeout", 1'b0, 1'b0, 16'o001000, 16'h0, 1'b1, 16'o012345, 21, 1'b0);
        wait_done("timeout", 3);
        chk("to_strobes", 32'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}), 32'hF);
        slv_en = 1'b1;

        // Back-to-back: req held through the done cycle
        start("b2b_1", 1'b0, 1'b0, 16'o100000, 16'h0, 1'b0, 16'o012345, 6, 1'b1);
        bus.addr = 16'h0200;
        begin
            exp_t e;
            e.name = "b2b_2"; e.err = 1'b0; e.rdata = 16'h3E5A; e.cyc = cyc - 1 + 12;
            exp_q.push_back(e);
        end
        wait_done("b2b_1", 4);
        @(posedge clk); #1;
        bus.req = 1'b0;
        chk("b2b_addr_phase", 32'({bus.busy, pin_sync_n, pin_ad_n}), 32'h3FDFF);
        wait_done("b2b_2", 5);

        // Reset in the data phase
        slv_wait = 10;
        start("rst_abort", 1'b0, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, 6, 1'b0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ra_in_data", 32'({pin_sync_n, pin_din_n}), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ra_strobes", 32'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}), 32'hF);
        chk("ra_busy_done_err", 32'({bus.busy, bus.done, bus.err}), 32'h0);
        chk_float("ra_ad_float");
        rst = 1'b0;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("ra_no_done", 32'(dcount), 32'h0);

        // Wait states
        slv_wait = 3;
        start("wait3", 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h3C4A, 9, 1'b0);
        wait_done("wait3", 6);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mpi_bus_master.md
# mpi_bus_master

Synchronous master for the BK-0010 multiplexed, active-low MPI bus. It sits directly upstream of the bus slaves: the ROM, RAM and register blocks that latch the address while `pin_sync_n` is high and answer `pin_din_n` with `pin_rply_n`. The block turns one-cycle host requests into full address/data bus transactions, with reply handshake and timeout. In the bench it stands in for the CPU bus unit that drives the ROM.

## Interface
- `TIMEOUT`, default 64: clock cycles to wait for `pin_rply_n` before aborting with error.
- `pin_clk` in 1: single clock; all state changes on its rising edge.
- `pin_rst` in 1: reset, synchronous and active-high.
- `req` in 1: start a transaction; sampled only when `busy`=0.
- `we` in 1: 1 = write (DATO/DATOB), 0 = read (DATI).
- `byte_en` in 1: byte write; `addr[0]` selects the byte lane; ignored on reads.
- `addr` in 16: byte address, true polarity.
- `wdata` in 16: write data, true polarity.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse when a transaction ends.
- `err` out 1: valid with `done`; 1 = reply timeout.
- `rdata` out 16: read data, true polarity; updated only on a successful read.
- `pin_sync_n` out 1: address strobe, active low.
- `pin_din_n` out 1: read strobe.
- `pin_dout_n` out 1: write strobe.
- `pin_wtbt_n` out 1: write/byte qualifier.
- `pin_ad_n` inout 16: multiplexed address/data, inverted; high-Z when not driven.
- `pin_rply_n` in 1: slave reply; resolves to 1 when undriven (bench pull-up); X/Z is treated as deasserted.

## Operation
- States: IDLE, ADDR, SYNC, DATA, END, REL.
- IDLE: all strobes high, `pin_ad_n` high-Z. When `req`=1, latch `we`/`byte_en`/`addr`/`wdata` and go to ADDR.
- ADDR, 1 cycle: drive `~addr` with `pin_sync_n`=1. This is address setup; slaves are transparent here. `pin_wtbt_n`=0 if write.
- SYNC, 1 cycle: `pin_sync_n`=0 and keep driving the address. The falling edge of sync is where slaves latch.
- DATA:
  - Read: release `pin_ad_n` and set `pin_din_n`=0.
  - Write: drive `~wdata` and set `pin_dout_n`=0; `pin_wtbt_n`=0 only if `byte_en`.
  - Each edge samples `pin_rply_n`. If it is 0, capture `rdata <= ~pin_ad_n` (read only) and go to END.
  - A timeout counter is loaded with TIMEOUT-1 on entry. If it expires with no reply, set an internal error flag and go to END.
- END, 1 cycle: deassert `din`/`dout`/`wtbt`, release `pin_ad_n`, and keep `pin_sync_n`=0.
- REL: `pin_sync_n`=1. Wait for `pin_rply_n`=1, with the counter reloaded.
  - On release or expiry, go to IDLE with `done`=1 for one cycle.
  - `err` = error flag OR REL expiry.
- `busy`=1 in every state except IDLE.
- `req` while `busy` is ignored. A `req` in the cycle where `done`=1 is accepted, so back-to-back transactions work.
- All bus outputs and the `pin_ad_n` drive enable are registered; no combinational path from `req` to the pins.
- Reset at any point, including mid-transaction: on the next edge go to IDLE, release the bus, set `done`=0 and `err`=0. No completion is reported for the aborted cycle.

## Timing
- Reset values:
  - `pin_sync_n`/`pin_din_n`/`pin_dout_n`/`pin_wtbt_n` = 1
  - `pin_ad_n` = Z
  - `busy`/`done`/`err` = 0
  - `rdata` = 0
- Zero-wait slave, with `req` sampled at edge 0:
  - ADDR in cycle 1, SYNC in cycle 2, DATA in cycle 3; reply is sampled at edge 3.
  - END in cycle 4, REL in cycle 5, and `done` is high in cycle 6.
  - So done latency is 6 cycles, and each added slave wait state adds 1.
- Timeout read with no slave: DATA lasts exactly TIMEOUT cycles. `done`=`err`=1 in cycle TIMEOUT+5.
- Address is stable on `pin_ad_n` for at least 1 cycle before and 1 cycle after `pin_sync_n` falls.

## Structure
- Package `mpi_pkg` holds the state enum, bus width 16, and the `DATI`/`DATO` encodings.
- Sub-module `mpi_timeout`: loadable down-counter with an expired flag, width `$clog2(TIMEOUT)`.

## Test plan
- ROM read: ROM image loaded with 16'o012345 at word 0. `req`, `we`=0, `addr`=16'o100000 → `done` in cycle 6, `rdata`=16'o012345, `err`=0.
- Byte write: `addr`=16'o001001, `byte_en`=1, `wdata`=16'h5A00.
  - Address phase: `pin_ad_n`=~16'o001001 with `pin_wtbt_n`=0.
  - Data phase: `pin_dout_n`=0, `pin_wtbt_n`=0, `pin_ad_n`=16'hA5FF.
  - Completes when the bench slave replies.
- Timeout: TIMEOUT=16, read `addr`=16'o001000 with no slave → `done`=`err`=1 at cycle 21, strobes all 1, `rdata` unchanged.
- Back-to-back: second `req` held high → accepted in the `done` cycle; the second transaction reaches ADDR on the next edge.
- Reset during DATA: bus strobes are 1 and `pin_ad_n` is Z after one edge, with no `done`. A later read then completes normally.
- Wait states: slave delays reply by 3 cycles → `done` at cycle 9, data correct.
